// File: rtl/register_file_pkg.sv
// Shared datapath constants for the CPU register file slice.
package cpu_pkg;

  localparam int WORD_W       = 8;
  localparam int NUM_REGS     = 8;
  localparam int REG_ADDR_W   = $clog2(NUM_REGS);
  localparam int ZERO_REG_IDX = 0;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback-side bus of the register file: one write port, two read ports.
interface register_file_if
  import cpu_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) ();

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b
  );

endinterface

// File: rtl/register_file_load_register.sv
// One WIDTH-bit register entry: synchronous active-high clear, load-gated capture.
module load_register
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/register_file.sv
// WIDTH x DEPTH register file: one synchronous write port, two combinational read
// ports, optional write-to-read bypass and hard-wired zero register.
module register_file
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = NUM_REGS,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_ZERO  = ADDR_W'(ZERO_REG_IDX);

  logic [WIDTH-1:0]  w_q      [DEPTH];
  logic [DEPTH-1:0]  w_load;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_raddr  [2];
  logic [WIDTH-1:0]  w_rdata  [2];

  // A write is effective only when in range, not to the zero register and not under reset.
  assign w_wr_ok = bus.we && !rst && ({1'b0, bus.waddr} < LP_DEPTH) &&
                   !((ZERO_REG != 0) && (bus.waddr == LP_ZERO));

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_load[g] = w_wr_ok && (bus.waddr == ADDR_W'(g));

    load_register #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .load (w_load[g]),
      .d    (bus.wdata),
      .q    (w_q[g])
    );
  end

  assign w_raddr[0] = bus.raddr_a;
  assign w_raddr[1] = bus.raddr_b;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      if (({1'b0, w_raddr[p]} < LP_DEPTH) &&
          !((ZERO_REG != 0) && (w_raddr[p] == LP_ZERO))) begin
        if ((BYPASS != 0) && w_wr_ok && (w_raddr[p] == bus.waddr)) begin
          w_rdata[p] = bus.wdata;
        end else begin
          w_rdata[p] = w_q[w_raddr[p]];
        end
      end
    end
  end

  assign bus.rdata_a = w_rdata[0];
  assign bus.rdata_b = w_rdata[1];

endmodule
